// File: rtl/y86_pipe_ctrl.sv
// Hazard-control and status unit for the five-stage Y86-64 pipeline.
// Pipeline-register stall/bubble controls, the architectural status latch and performance counters.
module y86_pipe_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          PRED_TAKEN = 1'b1,
    parameter logic [3:0]  RNONE      = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       m_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       w_stat,
    input  logic             w_valid,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic             set_cc_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    typedef enum logic [3:0] {
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_RET    = 4'h9,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    logic             loaduse;
    logic             retin;
    logic             mispred;
    logic             exc;

    logic [2:0]       stat_q,    stat_d;
    logic             halted_q,  halted_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

    assign loaduse = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                     (e_dstM != RNONE) &&
                     ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    assign retin   = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    assign mispred = (e_icode == I_JXX) && (PRED_TAKEN ? !e_cnd : e_cnd);
    assign exc     = halted_q || (m_stat != S_AOK) || (w_stat != S_AOK);

    // Rules are applied lowest priority first so the halted override lands last.
    always_comb begin
        f_stall   = loaduse || retin;
        d_stall   = loaduse;
        d_bubble  = mispred || (retin && !loaduse);
        e_bubble  = mispred || loaduse;
        m_bubble  = 1'b0;
        w_stall   = 1'b0;
        set_cc_en = (e_icode == I_OPQ);

        if (exc) begin
            m_bubble  = 1'b1;
            set_cc_en = 1'b0;
        end

        if (w_stat != S_AOK) begin
            w_stall = 1'b1;
        end

        if (halted_q) begin
            f_stall   = 1'b1;
            d_stall   = 1'b1;
            w_stall   = 1'b1;
            d_bubble  = 1'b0;
            e_bubble  = 1'b0;
            m_bubble  = 1'b0;
            set_cc_en = 1'b0;
        end
    end

    always_comb begin
        stat_d    = stat_q;
        halted_d  = halted_q;
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        bub_cnt_d = bub_cnt_q;

        // First faulting instruction to reach writeback freezes the status until reset.
        if (!halted_q && w_valid && (w_stat != S_AOK)) begin
            stat_d   = w_stat;
            halted_d = 1'b1;
        end

        if (!halted_q) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end

        if (w_valid && !w_stall) begin
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end

        if (!halted_q && (d_bubble || e_bubble || m_bubble)) begin
            bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q    <= S_AOK;
            halted_q  <= 1'b0;
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
            bub_cnt_q <= '0;
        end else begin
            stat_q    <= stat_d;
            halted_q  <= halted_d;
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign stat    = stat_q;
    assign halted  = halted_q;
    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
    assign bub_cnt = bub_cnt_q;

endmodule
